// File: rtl/period_counter_pkg.sv
// Board constants and small helpers shared by the period-measurement blocks.
package period_counter_pkg;

   localparam int BOARD_CLK_HZ       = 100_000_000;
   localparam int BOARD_CLK_MS_COUNT = BOARD_CLK_HZ / 1000;
   localparam int DEFAULT_PRD_W      = 10;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/period_counter_ms_tick_gen.sv
// Mod-CLK_MS_COUNT counter with a sync clear; tick is high during the last count of each ms.
module ms_tick_gen
   import period_counter_pkg::*;
#(
   parameter int CLK_MS_COUNT = BOARD_CLK_MS_COUNT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = cnt_w(CLK_MS_COUNT);
   localparam logic [CW-1:0] LAST = CW'(CLK_MS_COUNT - 1);

   logic [CW-1:0] t;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         t <= '0;
      else if (clr || t == LAST)
         t <= '0;
      else
         t <= t + 1'b1;
   end

   // Decoded from the register only, so the FSM can drive clr without a comb loop.
   assign tick = (t == LAST);

endmodule

// File: rtl/period_counter.sv
// Measures the time in ms between two rising edges of si, with saturation and
// first-edge timeout both reported as an all-ones period with ovf set.
//
//   state | meaning
//   IDLE  | ready for start; ms counter and period counter held clear
//   WAITE | waiting for the first rising edge; ms ticks count toward timeout
//   COUNT | counting ms until the second rising edge or saturation
//   DONE  | one-cycle done_tick; prd/ovf already loaded
module period_counter
   import period_counter_pkg::*;
#(
   parameter int CLK_MS_COUNT = BOARD_CLK_MS_COUNT,
   parameter int PRD_W        = DEFAULT_PRD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             si,
   output logic             ready,
   output logic             done_tick,
   output logic [PRD_W-1:0] prd,
   output logic             ovf
);

   typedef enum logic [1:0] {IDLE, WAITE, COUNT, DONE} state_t;

   localparam logic [PRD_W-1:0] P_MAX = '1;

   state_t           state, state_nx;
   logic             si_d, rise, tick, clr;
   logic [PRD_W-1:0] p, p_nx, prd_nx;
   logic             ovf_nx;

   ms_tick_gen #(.CLK_MS_COUNT(CLK_MS_COUNT)) u_ms_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .tick  (tick)
   );

   assign rise = si & ~si_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         si_d  <= 1'b0;
         p     <= '0;
         prd   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         si_d  <= si;
         p     <= p_nx;
         prd   <= prd_nx;
         ovf   <= ovf_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      p_nx      = p;
      prd_nx    = prd;
      ovf_nx    = ovf;
      clr       = 1'b0;
      ready     = 1'b0;
      done_tick = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            clr   = 1'b1;
            p_nx  = '0;
            if (start)
               state_nx = WAITE;
         end
         WAITE: begin
            if (rise) begin
               state_nx = COUNT;
               clr      = 1'b1;
               p_nx     = '0;
            end else if (tick) begin
               if (p == P_MAX) begin
                  state_nx = DONE;
                  prd_nx   = P_MAX;
                  ovf_nx   = 1'b1;
               end else begin
                  p_nx = p + 1'b1;
               end
            end
         end
         COUNT: begin
            // An edge landing on a ms wrap counts that wrap, so the result is floor(D/ms).
            if (tick && p == P_MAX) begin
               state_nx = DONE;
               prd_nx   = P_MAX;
               ovf_nx   = 1'b1;
            end else if (rise) begin
               state_nx = DONE;
               prd_nx   = p + PRD_W'(tick);
               ovf_nx   = 1'b0;
            end else if (tick) begin
               p_nx = p + 1'b1;
            end
         end
         DONE: begin
            done_tick = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_period_counter.sv
// Directed bench for period_counter: expected results queued at stimulus time, checked on done_tick.
module tb_period_counter;

   localparam int CLK_MS = 10;
   localparam int PW     = 4;
   localparam int CLK_MS2 = 100;
   localparam int PW2     = 10;

   logic          clk = 1'b0;
   logic          reset, start, si;
   logic          ready, done_tick, ovf;
   logic [PW-1:0] prd;

   logic           start2, si2;
   logic           ready2, done2, ovf2;
   logic [PW2-1:0] prd2;

   period_counter #(.CLK_MS_COUNT(CLK_MS), .PRD_W(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .si        (si),
      .ready     (ready),
      .done_tick (done_tick),
      .prd       (prd),
      .ovf       (ovf)
   );

   period_counter #(.CLK_MS_COUNT(CLK_MS2), .PRD_W(PW2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .start     (start2),
      .si        (si2),
      .ready     (ready2),
      .done_tick (done2),
      .prd       (prd2),
      .ovf       (ovf2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int prd;
      int ovf;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (done_tick) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", sbq.size(), 1);
         end else begin
            mon_e = sbq.pop_front();
            chk("done_prd", 32'(prd), mon_e.prd);
            chk("done_ovf", 32'(ovf), mon_e.ovf);
            chk("done_cyc", cyc, mon_e.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_si;
      si = 1'b1;
      tick(1);
      si = 1'b0;
   endtask

   task automatic do_start;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_q(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      chk("sb_drain", sbq.size(), 0);
      if (sbq.size() != 0) sbq.delete();
   endtask

   // Two single-cycle edges d clocks apart.
   task automatic measure(input int d);
      do_start;
      tick(2);
      pulse_si;
      tick(d - 1);
      sbq.push_back('{d / CLK_MS, 0, cyc + 1});
      si = 1'b1;
      tick(1);
      si = 1'b0;
      wait_q(d + 20);
      chk("ready_after", ready, 1);
   endtask

   initial begin
      int a;
      int s;
      reset  = 1'b1;
      start  = 1'b0;
      si     = 1'b0;
      start2 = 1'b0;
      si2    = 1'b0;
      tick(2);
      chk("rst_ready", ready, 1);
      chk("rst_done", done_tick, 0);
      chk("rst_prd", 32'(prd), 0);
      chk("rst_ovf", ovf, 0);
      reset = 1'b0;
      tick(1);

      measure(9);
      measure(59);
      measure(60);
      measure(50);

      // prd/ovf survive a new start; start pulses and held-high si inside COUNT change nothing
      do_start;
      chk("hold_prd", 32'(prd), 5);
      chk("hold_ovf", ovf, 0);
      chk("busy_ready", ready, 0);
      tick(1);
      a  = cyc;
      si = 1'b1;
      tick(5);
      do_start;
      tick(5);
      do_start;
      tick(5);
      si = 1'b0;
      tick(a + 40 - cyc);
      sbq.push_back('{40 / CLK_MS, 0, cyc + 1});
      si = 1'b1;
      tick(1);
      si = 1'b0;
      wait_q(40);

      // saturation: one edge, then nothing
      do_start;
      tick(1);
      a = cyc;
      sbq.push_back('{(1 << PW) - 1, 1, a + (1 << PW) * CLK_MS + 1});
      pulse_si;
      tick(170);
      wait_q(10);

      // timeout: no edge at all
      s = cyc;
      do_start;
      sbq.push_back('{(1 << PW) - 1, 1, s + (1 << PW) * CLK_MS + 1});
      tick(165);
      wait_q(10);

      // reset during COUNT aborts without done_tick
      do_start;
      tick(1);
      pulse_si;
      tick(20);
      chk("pre_rst_prd", 32'(prd), (1 << PW) - 1);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_prd", 32'(prd), 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_done", done_tick, 0);
      reset = 1'b0;
      tick(2);
      measure(30);
      chk("post_rst_prd", 32'(prd), 3);

      // wide instance: 120 ms period at 100 clocks per ms
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      tick(3);
      si2 = 1'b1;
      tick(1);
      si2 = 1'b0;
      tick(120 * CLK_MS2 - 1);
      si2 = 1'b1;
      tick(1);
      si2 = 1'b0;
      chk("w_done", done2, 1);
      chk("w_prd", 32'(prd2), 120);
      chk("w_ovf", ovf2, 0);
      tick(2);
      chk("w_ready", ready2, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
